// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard sequencer: load-use bubbles, multi-cycle EX holds, external stalls and mispredict flushes.
// Optional perf counters are built when PIPE_HAZARD_PERF_EN is defined.
module pipe_hazard_ctrl #(
  parameter int REG_IDX_WIDTH = 5,
  parameter int FLUSH_CYCLES  = 1,
  parameter int MC_TIMEOUT    = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     id_valid_i,
  input  logic [REG_IDX_WIDTH-1:0] id_rs1_idx_i,
  input  logic                     id_rs1_ren_i,
  input  logic [REG_IDX_WIDTH-1:0] id_rs2_idx_i,
  input  logic                     id_rs2_ren_i,
  input  logic                     id_ex_valid_i,
  input  logic [REG_IDX_WIDTH-1:0] id_ex_rd_idx_i,
  input  logic                     id_ex_rd_en_i,
  input  logic                     id_ex_is_load_i,
  input  logic                     ex_mispredict_i,
  input  logic                     ex_mc_start_i,
  input  logic                     ex_mc_done_i,
  input  logic                     ext_stall_i,
  output logic                     stall_pc_o,
  output logic                     stall_if_id_o,
  output logic                     stall_id_ex_o,
  output logic                     flush_if_id_o,
  output logic                     flush_id_ex_o,
  output logic                     mc_timeout_o,
  output logic [1:0]               state_o,
  output logic [31:0]              perf_stall_cnt_o,
  output logic [31:0]              perf_flush_cnt_o
);

  localparam int FCNT_W = $clog2(FLUSH_CYCLES + 1);
  localparam int TCNT_W = $clog2(MC_TIMEOUT + 1);
  localparam logic [FCNT_W-1:0] FLUSH_INIT = FCNT_W'(FLUSH_CYCLES - 1);
  localparam logic [TCNT_W-1:0] TCNT_MAX   = TCNT_W'(MC_TIMEOUT);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_MC_WAIT = 2'd1,
    ST_FLUSH   = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [FCNT_W-1:0]   fcnt_q, fcnt_d;
  logic [TCNT_W-1:0]   tcnt_q, tcnt_d;

  logic stall_pc_c, stall_if_id_c, stall_id_ex_c;
  logic flush_if_id_c, flush_id_ex_c, mc_timeout_c;
  logic load_use;

  // rd==x0 never creates a dependency since x0 is hard-wired
  assign load_use = id_valid_i & id_ex_valid_i & id_ex_is_load_i & id_ex_rd_en_i &
                    (id_ex_rd_idx_i != '0) &
                    ((id_rs1_ren_i & (id_rs1_idx_i == id_ex_rd_idx_i)) |
                     (id_rs2_ren_i & (id_rs2_idx_i == id_ex_rd_idx_i)));

  always_comb begin
    state_d       = state_q;
    fcnt_d        = fcnt_q;
    tcnt_d        = tcnt_q;
    stall_pc_c    = 1'b0;
    stall_if_id_c = 1'b0;
    stall_id_ex_c = 1'b0;
    flush_if_id_c = 1'b0;
    flush_id_ex_c = 1'b0;
    mc_timeout_c  = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (ext_stall_i) begin
          stall_pc_c    = 1'b1;
          stall_if_id_c = 1'b1;
          stall_id_ex_c = 1'b1;
        end else if (ex_mispredict_i) begin
          flush_if_id_c = 1'b1;
          flush_id_ex_c = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_d = ST_FLUSH;
            fcnt_d  = FLUSH_INIT;
          end
        end else if (ex_mc_start_i && !ex_mc_done_i) begin
          stall_pc_c    = 1'b1;
          stall_if_id_c = 1'b1;
          stall_id_ex_c = 1'b1;
          state_d       = ST_MC_WAIT;
          tcnt_d        = TCNT_W'(1);
        end else if (!ex_mc_start_i && load_use) begin
          stall_pc_c    = 1'b1;
          stall_if_id_c = 1'b1;
          flush_id_ex_c = 1'b1;
        end
      end
      ST_MC_WAIT: begin
        // An external stall still freezes the front end on the exit cycle
        if (ex_mc_done_i || (tcnt_q == TCNT_MAX)) begin
          mc_timeout_c  = ~ex_mc_done_i;
          state_d       = ST_RUN;
          stall_pc_c    = ext_stall_i;
          stall_if_id_c = ext_stall_i;
          stall_id_ex_c = ext_stall_i;
        end else begin
          stall_pc_c    = 1'b1;
          stall_if_id_c = 1'b1;
          stall_id_ex_c = 1'b1;
          tcnt_d        = tcnt_q + TCNT_W'(1);
        end
      end
      ST_FLUSH: begin
        if (ext_stall_i) begin
          stall_pc_c    = 1'b1;
          stall_if_id_c = 1'b1;
          stall_id_ex_c = 1'b1;
        end else begin
          flush_if_id_c = 1'b1;
          if (fcnt_q == FCNT_W'(1)) begin
            state_d = ST_RUN;
          end else begin
            fcnt_d = fcnt_q - FCNT_W'(1);
          end
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
      fcnt_q  <= '0;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      tcnt_q  <= tcnt_d;
    end
  end

  assign stall_pc_o    = stall_pc_c    & ~rst;
  assign stall_if_id_o = stall_if_id_c & ~rst;
  assign stall_id_ex_o = stall_id_ex_c & ~rst;
  assign flush_if_id_o = flush_if_id_c & ~rst;
  assign flush_id_ex_o = flush_id_ex_c & ~rst;
  assign mc_timeout_o  = mc_timeout_c  & ~rst;
  assign state_o       = state_q;

`ifdef PIPE_HAZARD_PERF_EN
  logic [31:0] perf_stall_q, perf_stall_d;
  logic [31:0] perf_flush_q, perf_flush_d;
  logic        mp_accept;

  assign mp_accept = ~rst & (state_q == ST_RUN) & ~ext_stall_i & ex_mispredict_i;

  // Both counters saturate rather than wrap
  always_comb begin
    perf_stall_d = perf_stall_q;
    perf_flush_d = perf_flush_q;
    if (stall_pc_o && (perf_stall_q != 32'hFFFF_FFFF)) begin
      perf_stall_d = perf_stall_q + 32'd1;
    end
    if (mp_accept && (perf_flush_q != 32'hFFFF_FFFF)) begin
      perf_flush_d = perf_flush_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_q <= 32'h0;
      perf_flush_q <= 32'h0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_flush_q <= perf_flush_d;
    end
  end

  assign perf_stall_cnt_o = perf_stall_q;
  assign perf_flush_cnt_o = perf_flush_q;
`else
  assign perf_stall_cnt_o = 32'h0;
  assign perf_flush_cnt_o = 32'h0;
`endif

endmodule
